top_level: RTL and testbench



---
 rtl/top_level.sv | 181 ++++++++++++++++++
 tb/tb_top_level.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/top_level.sv
// Sequential 8-bit ALU: add/sub, radix-2 Booth multiply, unsigned restoring divide.
// Latency from start edge: add/sub 3 cycles, mul 11, div 12 (div by zero 3), then two output bytes.
// No backpressure: start is only accepted in IDLE and ignored while an operation is in flight.
module top_level (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inbus,
    input  logic [1:0] op,
    input  logic       start,
    output logic [7:0] outbus,
    output logic       finish,
    output logic [3:0] state,
    output logic [7:0] A,
    output logic [7:0] Q,
    output logic [7:0] M
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD1  = 4'd1,
        S_LOAD2  = 4'd2,
        S_LOAD3  = 4'd3,
        S_ADDSUB = 4'd4,
        S_MUL    = 4'd5,
        S_DIV    = 4'd6,
        S_OUT_HI = 4'd7,
        S_OUT_LO = 4'd8
    } state_t;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state_q, state_d;
    logic [8:0]  a_q, a_d;      // 9 bits so Booth partial products never overflow
    logic [7:0]  q_q, q_d;
    logic [7:0]  m_q, m_d;
    logic        qm1_q, qm1_d;  // Booth Q-1 bit
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;

    logic [8:0]  m_sx;
    logic [8:0]  r9;
    logic [8:0]  booth_sum;
    logic [8:0]  div_sh;
    logic [8:0]  div_tr;
    logic        div_ok;

    // Datapath arithmetic shared by the execute states
    always_comb begin
        m_sx = {m_q[7], m_q};
        if (op_q == OP_SUB) r9 = m_sx - {q_q[7], q_q};
        else                r9 = m_sx + {q_q[7], q_q};
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = a_q + m_sx;
            2'b10:   booth_sum = a_q - m_sx;
            default: booth_sum = a_q;
        endcase
        // Restoring step: shift {A,Q} left by one, then trial-subtract the divisor
        div_sh = {a_q[7:0], q_q[7]};
        div_tr = div_sh - {1'b0, m_q};
        div_ok = (div_sh >= {1'b0, m_q});
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    state_d = S_LOAD1;
                end
            end
            S_LOAD1: begin
                if (op_q == OP_DIV) a_d = {1'b0, inbus};
                else                m_d = inbus;
                state_d = S_LOAD2;
            end
            S_LOAD2: begin
                q_d = inbus;
                if (op_q == OP_DIV) begin
                    state_d = S_LOAD3;
                end else if (op_q == OP_MUL) begin
                    a_d     = 9'd0;
                    qm1_d   = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = S_MUL;
                end else begin
                    state_d = S_ADDSUB;
                end
            end
            S_LOAD3: begin
                m_d   = inbus;
                cnt_d = 4'd0;
                if (inbus == 8'd0) begin
                    // Divide by zero reports all-ones quotient and remainder
                    a_d     = 9'h0FF;
                    q_d     = 8'hFF;
                    state_d = S_OUT_HI;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_ADDSUB: begin
                a_d     = {9{r9[8]}};
                q_d     = r9[7:0];
                state_d = S_OUT_HI;
            end
            S_MUL: begin
                if (cnt_q == 4'd8) begin
                    state_d = S_OUT_HI;
                end else begin
                    a_d   = {booth_sum[8], booth_sum[8:1]};
                    q_d   = {booth_sum[0], q_q[7:1]};
                    qm1_d = q_q[0];
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == 4'd8) begin
                    state_d = S_OUT_HI;
                end else begin
                    a_d   = div_ok ? div_tr : div_sh;
                    q_d   = {q_q[6:0], div_ok};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_OUT_HI: state_d = S_OUT_LO;
            S_OUT_LO: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= 9'd0;
            q_q     <= 8'd0;
            m_q     <= 8'd0;
            qm1_q   <= 1'b0;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Moore output decode: divide emits quotient first, everything else high byte first
    always_comb begin
        outbus = 8'd0;
        finish = 1'b0;
        case (state_q)
            S_OUT_HI: begin
                finish = 1'b1;
                outbus = (op_q == OP_DIV) ? q_q : a_q[7:0];
            end
            S_OUT_LO: outbus = (op_q == OP_DIV) ? a_q[7:0] : q_q;
            default: ;
        endcase
    end

    assign state = state_q;
    assign A     = a_q[7:0];
    assign Q     = q_q;
    assign M     = m_q;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for the sequential ALU against an arithmetic reference model.
// Covers directed corner cases, random back-to-back ops, spurious starts and mid-op reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_top_level;

    logic       clk;
    logic       rst;
    logic [7:0] inbus;
    logic [1:0] op;
    logic       start;
    logic [7:0] outbus;
    logic       finish;
    logic [3:0] state;
    logic [7:0] A, Q, M;

    int checks   = 0;
    int errors   = 0;
    int fin_seen = 0;
    int ops_done = 0;

    top_level dut (
        .clk    (clk),
        .rst    (rst),
        .inbus  (inbus),
        .op     (op),
        .start  (start),
        .outbus (outbus),
        .finish (finish),
        .state  (state),
        .A      (A),
        .Q      (Q),
        .M      (M)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Count every cycle that finish is seen high
    always @(negedge clk) if (rst && finish) fin_seen++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand bytes
    task automatic model(input logic [1:0] o, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, output logic [15:0] res, output int lat);
        int s1, s2;
        int unsigned dv, qq, rr;
        s1 = int'($signed(b1));
        s2 = int'($signed(b2));
        case (o)
            2'd0: begin res = 16'(s1 + s2); lat = 3; end
            2'd1: begin res = 16'(s1 - s2); lat = 3; end
            2'd2: begin res = 16'(s1 * s2); lat = 11; end
            default: begin
                if (b3 == 8'd0) begin
                    res = 16'hFFFF;
                    lat = 3;
                end else begin
                    dv  = {16'd0, b1, b2};
                    qq  = dv / int'(b3);
                    rr  = dv % int'(b3);
                    res = {qq[7:0], rr[7:0]};
                    lat = 12;
                end
            end
        endcase
    endtask

    // One full operation starting from IDLE at a falling edge; ends at a falling edge in IDLE
    task automatic run_op(input logic [1:0] o, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input bit noise);
        logic [15:0] res;
        int lat, k;
        model(o, b1, b2, b3, res, lat);
        start = 1'b1;
        op    = o;
        inbus = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        chk("load1_state", 16'(state), 16'd1);
        inbus = b1;
        @(posedge clk);
        @(negedge clk);
        inbus = b2;
        if (noise) start = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        k = 2;
        inbus = (o == 2'd3) ? b3 : 8'($urandom);
        if (noise) start = 1'($urandom_range(0, 1));
        while (!finish && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (!finish) begin
                inbus = 8'($urandom);
                if (noise) start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        chk("latency", 16'(k), 16'(lat));
        chk("out_hi", {8'd0, outbus}, {8'd0, res[15:8]});
        chk("fin_hi", {15'd0, finish}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        chk("out_lo", {8'd0, outbus}, {8'd0, res[7:0]});
        chk("fin_lo", {15'd0, finish}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("idle", 16'(state), 16'd0);
        ops_done++;
    endtask

    initial begin
        logic [7:0] r1, r2, r3;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        inbus = 8'd0;
        #2 rst = 1'b0;
        #10;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_out", {8'd0, outbus}, 16'd0);
        chk("rst_fin", {15'd0, finish}, 16'd0);
        chk("rst_aqm", {A, Q | M}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(2'd0, 8'd100, 8'd27, 8'd0, 1'b0);
        run_op(2'd0, 8'd127, 8'd127, 8'd0, 1'b0);
        run_op(2'd0, 8'h80, 8'hFF, 8'd0, 1'b0);
        run_op(2'd1, 8'd5, 8'd10, 8'd0, 1'b0);
        run_op(2'd1, 8'h80, 8'd127, 8'd0, 1'b0);
        run_op(2'd2, 8'hFD, 8'd7, 8'd0, 1'b0);
        run_op(2'd2, 8'h80, 8'h80, 8'd0, 1'b0);
        run_op(2'd2, 8'd0, 8'hFB, 8'd0, 1'b0);
        run_op(2'd3, 8'h12, 8'h34, 8'h56, 1'b0);
        run_op(2'd3, 8'h00, 8'h64, 8'h07, 1'b0);
        run_op(2'd3, 8'h12, 8'h34, 8'h00, 1'b0);

        // Random back-to-back ops with spurious start pulses while busy
        for (int o = 0; o < 4; o++) begin
            for (int n = 0; n < 8; n++) begin
                r1 = 8'($urandom);
                r2 = 8'($urandom);
                r3 = 8'($urandom_range(1, 255));
                if (o == 3) r1 = 8'($urandom_range(0, int'(r3) - 1));
                run_op(2'(o), r1, r2, r3, 1'b1);
            end
        end

        // Asynchronous reset in the middle of a multiply
        start = 1'b1;
        op    = 2'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        inbus = 8'd5;
        @(posedge clk);
        @(negedge clk);
        inbus = 8'd9;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_state", 16'(state), 16'd0);
        chk("mid_rst_A", {8'd0, A}, 16'd0);
        chk("mid_rst_Q", {8'd0, Q}, 16'd0);
        chk("mid_rst_M", {8'd0, M}, 16'd0);
        chk("mid_rst_fin", {15'd0, finish}, 16'd0);
        chk("mid_rst_out", {8'd0, outbus}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(2'd2, 8'hFD, 8'd7, 8'd0, 1'b0);
        run_op(2'd3, 8'h12, 8'h34, 8'h56, 1'b0);

        @(negedge clk);
        chk("finish_count", 16'(fin_seen), 16'(ops_done));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
